// File: rtl/mdl_sched_pkg.sv
`default_nettype none
// =============================================================================
// Package     : mdl_sched_pkg
// Description : Shared types and constants for the command scheduler. The op
//               codes match the existing engine mode encoding, so commands can
//               be forwarded without translation.
// Contents    : op_t, OP_KECCAK, OP_BUT, state_t (IDLE/WAIT), entryWidth(),
//               isLegalOp()
// Revision    : 1.0 - initial release
// =============================================================================
package mdl_sched_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_KECCAK = 2'd1;
  localparam op_t OP_BUT    = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // A queue entry is {op, rep}.
  function automatic int entryWidth(input int cntW);
    return 2 + cntW;
  endfunction

  // Only the two engine codes are legal; 0 and 3 are rejected at pop time.
  function automatic logic isLegalOp(input op_t op);
    return (op == OP_KECCAK) || (op == OP_BUT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdl_cmd_sched_if.sv
`default_nettype none
// =============================================================================
// Interface   : mdl_cmd_sched_if
// Description : Host command push port, engine start/done handshake and the
//               status/error lines of the command scheduler.
// Modports    : slave  - the scheduler (consumes commands, drives starts)
//               master - host plus engines (drives commands and done pulses)
// Signals     : iCMD_VALID/oCMD_READY/iCMD_OP/iCMD_REP  command push
//               oFSM_*_START / iFSM_*_DONE               engine handshake
//               oCMD_DONE, oBUSY, oERR, iERR_CLR         status
// Revision    : 1.0 - initial release
// =============================================================================
interface mdl_cmd_sched_if #(
  parameter int CNT_W = 8
);
  import mdl_sched_pkg::*;

  logic             iCMD_VALID;
  logic             oCMD_READY;
  op_t              iCMD_OP;
  logic [CNT_W-1:0] iCMD_REP;
  logic             iFSM_BUT_DONE;
  logic             iFSM_KECCAK_DONE;
  logic             oFSM_BUT_START;
  logic             oFSM_KECCAK_START;
  logic             oCMD_DONE;
  logic             oBUSY;
  logic             oERR;
  logic             iERR_CLR;

  modport slave (
    input  iCMD_VALID, iCMD_OP, iCMD_REP,
    input  iFSM_BUT_DONE, iFSM_KECCAK_DONE, iERR_CLR,
    output oCMD_READY, oFSM_BUT_START, oFSM_KECCAK_START,
    output oCMD_DONE, oBUSY, oERR
  );

  modport master (
    output iCMD_VALID, iCMD_OP, iCMD_REP,
    output iFSM_BUT_DONE, iFSM_KECCAK_DONE, iERR_CLR,
    input  oCMD_READY, oFSM_BUT_START, oFSM_KECCAK_START,
    input  oCMD_DONE, oBUSY, oERR
  );

endinterface
`default_nettype wire

// File: rtl/mdl_cmd_fifo.sv
`default_nettype none
// =============================================================================
// Module      : mdl_cmd_fifo
// Description : Synchronous FIFO with wrap-around pointers and an occupancy
//               counter. Read data is the head entry, available without a
//               read strobe (show-ahead).
// Ports       : iSYS_CLK  clock
//               iSYS_RST  asynchronous active-high reset (empties the FIFO)
//               iPUSH     write request, ignored while full
//               iPOP      read request, ignored while empty
//               iDATA     write data
//               oDATA     head entry
//               oFULL, oEMPTY, oCOUNT  occupancy status
// Revision    : 1.0 - initial release
// =============================================================================
module mdl_cmd_fifo #(
  parameter  int DEPTH   = 4,
  parameter  int WIDTH   = 10,
  localparam int c_PTR_W = $clog2(DEPTH),
  localparam int c_CNT_W = c_PTR_W + 1
) (
  input  wire logic               iSYS_CLK,
  input  wire logic               iSYS_RST,
  input  wire logic               iPUSH,
  input  wire logic               iPOP,
  input  wire logic [WIDTH-1:0]   iDATA,
  output logic      [WIDTH-1:0]   oDATA,
  output logic                    oFULL,
  output logic                    oEMPTY,
  output logic      [c_CNT_W-1:0] oCOUNT
);

  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign oFULL    = (r_count == c_FULL_CNT);
  assign oEMPTY   = (r_count == '0);
  assign oCOUNT   = r_count;
  assign oDATA    = r_mem[r_rdPtr];

  assign w_doPush = iPUSH && !oFULL;
  assign w_doPop  = iPOP && !oEMPTY;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge iSYS_CLK) begin
    if (w_doPush) r_mem[r_wrPtr] <= iDATA;
  end

endmodule
`default_nettype wire

// File: rtl/mdl_cmd_sched.sv
`default_nettype none
// =============================================================================
// Module      : mdl_cmd_sched
// Description : Command scheduler sharing the butterfly (BUT) unit and the
//               Keccak core between software jobs. Commands {op, rep} are
//               queued; each one starts its engine rep+1 times, waiting for
//               the engine done pulse between runs, then pulses oCMD_DONE.
// Ports       : iSYS_CLK  system clock
//               iSYS_RST  asynchronous active-high reset
//               bus       mdl_cmd_sched_if.slave: command push, engine
//                         start/done handshake, busy/done/error status
// Revision    : 1.0 - initial release
// =============================================================================
module mdl_cmd_sched
  import mdl_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input wire logic         iSYS_CLK,
  input wire logic         iSYS_RST,
  mdl_cmd_sched_if.slave   bus
);

  localparam int                 c_ENTRY_W   = entryWidth(CNT_W);
  localparam int                 c_CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic [c_ENTRY_W-1:0] w_pushData;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CNT_W-1:0]   w_count;
  op_t                  w_headOp;
  logic [CNT_W-1:0]     w_headRep;

  assign w_pushData = {bus.iCMD_OP, bus.iCMD_REP};
  assign w_push     = bus.iCMD_VALID && !w_full;
  assign {w_headOp, w_headRep} = w_head;

  mdl_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .iSYS_CLK (iSYS_CLK),
    .iSYS_RST (iSYS_RST),
    .iPUSH    (w_push),
    .iPOP     (w_pop),
    .iDATA    (w_pushData),
    .oDATA    (w_head),
    .oFULL    (w_full),
    .oEMPTY   (w_empty),
    .oCOUNT   (w_count)
  );

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_nextState;
  op_t              r_curOp;
  op_t              w_nextOp;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_nextRem;
  logic             r_butStart;
  logic             r_keccakStart;
  logic             r_cmdDone;
  logic             r_err;
  logic             w_nextButStart;
  logic             w_nextKeccakStart;
  logic             w_nextCmdDone;
  logic             w_nextErr;
  logic             w_errSet;
  logic             w_doneHit;

  // A done pulse counts only from the engine currently selected, and never in
  // the same cycle its start is still high: an engine cannot finish in zero
  // cycles, so such a pulse belongs to an earlier, unrelated job.
  always_comb begin
    w_doneHit = 1'b0;
    if (r_curOp == OP_BUT)
      w_doneHit = bus.iFSM_BUT_DONE && !r_butStart;
    else if (r_curOp == OP_KECCAK)
      w_doneHit = bus.iFSM_KECCAK_DONE && !r_keccakStart;
  end

  always_comb begin
    w_nextState       = r_state;
    w_nextOp          = r_curOp;
    w_nextRem         = r_rem;
    w_nextButStart    = 1'b0;
    w_nextKeccakStart = 1'b0;
    w_nextCmdDone     = 1'b0;
    w_pop             = 1'b0;
    w_errSet          = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (isLegalOp(w_headOp)) begin
            w_nextState       = WAIT;
            w_nextOp          = w_headOp;
            w_nextRem         = w_headRep;
            w_nextButStart    = (w_headOp == OP_BUT);
            w_nextKeccakStart = (w_headOp == OP_KECCAK);
          end else begin
            // Illegal entries are dropped without touching any engine.
            w_errSet = 1'b1;
          end
        end
      end

      WAIT: begin
        if (w_doneHit) begin
          if (r_rem == '0) begin
            w_nextCmdDone = 1'b1;
            w_nextState   = IDLE;
          end else begin
            w_nextRem         = r_rem - 1'b1;
            w_nextButStart    = (r_curOp == OP_BUT);
            w_nextKeccakStart = (r_curOp == OP_KECCAK);
          end
        end
      end

      default: w_nextState = IDLE;
    endcase

    // A new illegal pop wins over a simultaneous clear request.
    if (w_errSet)
      w_nextErr = 1'b1;
    else if (bus.iERR_CLR)
      w_nextErr = 1'b0;
    else
      w_nextErr = r_err;
  end

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      r_state       <= IDLE;
      r_curOp       <= '0;
      r_rem         <= '0;
      r_butStart    <= 1'b0;
      r_keccakStart <= 1'b0;
      r_cmdDone     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_curOp       <= w_nextOp;
      r_rem         <= w_nextRem;
      r_butStart    <= w_nextButStart;
      r_keccakStart <= w_nextKeccakStart;
      r_cmdDone     <= w_nextCmdDone;
      r_err         <= w_nextErr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.oCMD_READY        = (w_count != c_DEPTH_CNT);
  assign bus.oBUSY             = (r_state != IDLE) || !w_empty;
  assign bus.oFSM_BUT_START    = r_butStart;
  assign bus.oFSM_KECCAK_START = r_keccakStart;
  assign bus.oCMD_DONE         = r_cmdDone;
  assign bus.oERR              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdl_cmd_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_mdl_cmd_sched
// Description : Directed self-checking bench for mdl_cmd_sched. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mdl_cmd_sched;
  import mdl_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    op_t              op;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdl_cmd_sched_if #(.CNT_W(CNT_W)) bus();

  mdl_cmd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iSYS_CLK (clk),
    .iSYS_RST (rst),
    .bus      (bus)
  );

  logic manB = 1'b0, manK = 1'b0, autoB = 1'b0, autoK = 1'b0;
  assign bus.iFSM_BUT_DONE    = manB | autoB;
  assign bus.iFSM_KECCAK_DONE = manK | autoK;

  int nVec = 0;
  int nMis = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a command list plus the command in flight, expressed as
  // runs completed versus runs requested.
  // ---------------------------------------------------------------------------
  cmd_t mq[$];
  bit   mRun = 0, mStartB = 0, mStartK = 0, mDone = 0, mErr = 0;
  op_t  mOp = 2'd0;
  int   mRunsDone = 0, mRunsTotal = 0, mDoneCnt = 0;
  op_t  mDoneOps[$];

  task automatic modelReset();
    mq.delete();
    mRun = 0; mStartB = 0; mStartK = 0; mDone = 0; mErr = 0;
    mOp = 2'd0; mRunsDone = 0; mRunsTotal = 0;
  endtask

  task automatic modelStep();
    bit   pB, pK, hit;
    int   pSize;
    cmd_t head;
    pB = mStartB; pK = mStartK; pSize = mq.size();
    mStartB = 0; mStartK = 0; mDone = 0;
    if (bus.iERR_CLR) mErr = 0;
    if (mRun) begin
      hit = (mOp == OP_BUT) ? (bus.iFSM_BUT_DONE && !pB) : (bus.iFSM_KECCAK_DONE && !pK);
      if (hit) begin
        mRunsDone++;
        if (mRunsDone == mRunsTotal) begin
          mRun = 0; mDone = 1; mDoneCnt++; mDoneOps.push_back(mOp);
        end else begin
          mStartB = (mOp == OP_BUT); mStartK = (mOp == OP_KECCAK);
        end
      end
    end else if (pSize != 0) begin
      head = mq.pop_front();
      if (head.op == OP_BUT || head.op == OP_KECCAK) begin
        mRun = 1; mOp = head.op; mRunsDone = 0; mRunsTotal = int'(head.rep) + 1;
        mStartB = (mOp == OP_BUT); mStartK = (mOp == OP_KECCAK);
      end else begin
        mErr = 1;
      end
    end
    if (bus.iCMD_VALID && pSize < DEPTH) mq.push_back({bus.iCMD_OP, bus.iCMD_REP});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  // ---------------------------------------------------------------------------
  // Engine responder: answers each start with a done respDelay+1 edges later.
  // ---------------------------------------------------------------------------
  bit respEn = 0;
  int respDelay = 4;
  int cntB = 0, cntK = 0;

  task automatic respStep();
    autoB = 1'b0; autoK = 1'b0;
    if (rst || !respEn) begin
      cntB = 0; cntK = 0;
    end else begin
      if (cntB != 0) begin cntB--; if (cntB == 0) autoB = 1'b1; end
      if (cntK != 0) begin cntK--; if (cntK == 0) autoK = 1'b1; end
      if (bus.oFSM_BUT_START)    cntB = respDelay;
      if (bus.oFSM_KECCAK_START) cntK = respDelay;
    end
  endtask

  always @(negedge clk) respStep();

  // Observed DUT events, for scenario-level literal checks.
  int  nBS = 0, nKS = 0, nCD = 0;
  op_t startLog[$];

  task automatic monStep();
    if (bus.oFSM_BUT_START)    begin nBS++; startLog.push_back(OP_BUT); end
    if (bus.oFSM_KECCAK_START) begin nKS++; startLog.push_back(OP_KECCAK); end
    if (bus.oCMD_DONE) nCD++;
  endtask

  always @(negedge clk) monStep();

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      chk("cyc_butStart", bus.oFSM_BUT_START, mStartB);
      chk("cyc_kecStart", bus.oFSM_KECCAK_START, mStartK);
      chk("cyc_cmdDone", bus.oCMD_DONE, mDone);
      chk("cyc_err", bus.oERR, mErr);
      chk("cyc_ready", bus.oCMD_READY, mq.size() != DEPTH);
      chk("cyc_busy", bus.oBUSY, mRun || (mq.size() != 0));
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic push(input op_t op, input logic [CNT_W-1:0] rep);
    bus.iCMD_OP = op; bus.iCMD_REP = rep; bus.iCMD_VALID = 1'b1;
    step();
    bus.iCMD_VALID = 1'b0;
  endtask

  task automatic pulseB();
    manB = 1'b1; step(); manB = 1'b0;
  endtask

  task automatic waitDone(input int target, input int bound);
    for (int i = 0; i < bound && nCD < target; i++) step();
    chk("waitCmdDone", nCD, target);
  endtask

  op_t expOrd[5] = '{OP_BUT, OP_KECCAK, OP_BUT, OP_KECCAK, OP_BUT};
  int  b0, k0, d0, md0, s0, ms0;

  initial begin
    bus.iCMD_VALID = 1'b0; bus.iCMD_OP = 2'd0; bus.iCMD_REP = '0; bus.iERR_CLR = 1'b0;
    step();
    fork compareLoop(); join_none
    step(); step();
    chk("rst_ready", bus.oCMD_READY, 1);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_err", bus.oERR, 0);
    chk("rst_starts", {bus.oFSM_BUT_START, bus.oFSM_KECCAK_START}, 0);
    rst = 1'b0;
    step();

    // Single BUT command, rep = 0.
    d0 = nCD;
    push(OP_BUT, 0);
    chk("t1_noStartYet", bus.oFSM_BUT_START, 0);
    chk("t1_busyQueued", bus.oBUSY, 1);
    step();
    chk("t1_start", bus.oFSM_BUT_START, 1);
    chk("t1_noKec", bus.oFSM_KECCAK_START, 0);
    step();
    chk("t1_startOneCycle", bus.oFSM_BUT_START, 0);
    pulseB();
    chk("t1_cmdDone", bus.oCMD_DONE, 1);
    step();
    chk("t1_doneOneCycle", bus.oCMD_DONE, 0);
    chk("t1_idle", bus.oBUSY, 0);
    chk("t1_doneCount", nCD - d0, 1);

    // Keccak with rep = 2: three runs.
    b0 = nBS; k0 = nKS; d0 = nCD; md0 = mDoneCnt;
    respDelay = 4; respEn = 1;
    push(OP_KECCAK, 2);
    waitDone(d0 + 1, 200);
    repeat (10) step();
    chk("t2_kecStarts", nKS - k0, 3);
    chk("t2_butStarts", nBS - b0, 0);
    chk("t2_cmdDones", nCD - d0, 1);
    chk("t2_modelDones", mDoneCnt - md0, 1);
    chk("t2_idle", bus.oBUSY, 0);
    respEn = 0;

    // Full queue behind a stalled BUT command.
    b0 = nBS; k0 = nKS; d0 = nCD; s0 = startLog.size(); ms0 = mDoneOps.size();
    push(OP_BUT, 0);
    step();
    push(OP_KECCAK, 0); push(OP_BUT, 0); push(OP_KECCAK, 0);
    chk("t3_readyAt3", bus.oCMD_READY, 1);
    push(OP_BUT, 0);
    chk("t3_readyFull", bus.oCMD_READY, 0);
    push(OP_KECCAK, 5);
    chk("t3_stillFull", bus.oCMD_READY, 0);
    chk("t3_noDoneStalled", nCD - d0, 0);
    respEn = 1;
    pulseB();
    waitDone(d0 + 5, 400);
    repeat (20) step();
    chk("t3_cmdDones", nCD - d0, 5);
    chk("t3_butStarts", nBS - b0, 3);
    chk("t3_kecStarts", nKS - k0, 2);
    chk("t3_logLen", startLog.size() - s0, 5);
    for (int i = 0; i < 5; i++) begin
      if (s0 + i < startLog.size()) chk("t3_startOrder", startLog[s0 + i], expOrd[i]);
      if (ms0 + i < mDoneOps.size()) chk("t3_modelOrder", mDoneOps[ms0 + i], expOrd[i]);
    end
    chk("t3_idle", bus.oBUSY, 0);
    respEn = 0;

    // Cross-talk: coincident done and non-selected done are both ignored.
    d0 = nCD;
    push(OP_BUT, 0);
    step();
    chk("t4_start", bus.oFSM_BUT_START, 1);
    manB = 1'b1; step(); manB = 1'b0;
    chk("t4_coincIgnored", bus.oCMD_DONE, 0);
    manK = 1'b1; step(); manK = 1'b0;
    chk("t4_kecIgnored", bus.oCMD_DONE, 0);
    chk("t4_stillBusy", bus.oBUSY, 1);
    step(); step();
    pulseB();
    chk("t4_done", bus.oCMD_DONE, 1);
    chk("t4_doneCount", nCD - d0, 1);

    // Illegal op, then a legal BUT command.
    b0 = nBS; k0 = nKS;
    step();
    push(2'd3, 0);
    push(OP_BUT, 0);
    chk("t5_errSet", bus.oERR, 1);
    chk("t5_noStartIllegal", bus.oFSM_BUT_START, 0);
    step();
    chk("t5_butStart", bus.oFSM_BUT_START, 1);
    step();
    pulseB();
    chk("t5_butDone", bus.oCMD_DONE, 1);
    push(2'd0, 7);
    bus.iERR_CLR = 1'b1; step(); bus.iERR_CLR = 1'b0;
    chk("t5_setBeatsClr", bus.oERR, 1);
    bus.iERR_CLR = 1'b1; step(); bus.iERR_CLR = 1'b0;
    chk("t5_cleared", bus.oERR, 0);
    chk("t5_butStarts", nBS - b0, 1);
    chk("t5_kecStarts", nKS - k0, 0);

    // Reset mid-run with two commands queued.
    push(OP_BUT, 1);
    push(OP_KECCAK, 0);
    push(OP_BUT, 0);
    step();
    pulseB();
    chk("t6_reissue", bus.oFSM_BUT_START, 1);
    chk("t6_busy", bus.oBUSY, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rstButStart", bus.oFSM_BUT_START, 0);
    chk("t6_rstKecStart", bus.oFSM_KECCAK_START, 0);
    chk("t6_rstCmdDone", bus.oCMD_DONE, 0);
    chk("t6_rstReady", bus.oCMD_READY, 1);
    chk("t6_rstBusy", bus.oBUSY, 0);
    step(); step();
    rst = 1'b0;
    d0 = nCD;
    step();
    pulseB();
    chk("t6_lateDone", bus.oCMD_DONE, 0);
    step();
    chk("t6_noDoneCount", nCD - d0, 0);
    chk("t6_idle", bus.oBUSY, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
